// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its decoder-side users.
package imem_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        PROG  = 2'd2
    } state_t;

    // NOP instruction is all zeros; sized generously and cast down at use
    localparam logic [63:0] NOP_WORD = '0;

    // Opcode field width shared with the decoder
    localparam int OPCODE_W = 4;

endpackage

// File: rtl/imem_if.sv
// Fetch request/response handshake between program counter and instruction memory.
interface imem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;

    // Requester side (program counter / decoder)
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    // Memory side
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// No reset on the storage or the read register.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; caller guarantees waddr < DEPTH when we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; rdata holds its value until the next enabled read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with valid/ready fetch port, clear-to-NOP after reset,
// run-time programming mode and out-of-range fault reporting.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_if.slave             fetch,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy
);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP       = DATA_W'(NOP_WORD);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("imem_fetch: DEPTH must be within 1..2**ADDR_W");
    end
    if (DATA_W < OPCODE_W) begin : g_bad_width
        $error("imem_fetch: DATA_W too narrow for the opcode field");
    end

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              req_in_range;
    logic              prog_in_range;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              rsp_valid_q;
    logic              rsp_fault_q;

    assign req_in_range  = {1'b0, fetch.req_addr} < DEPTH_EXT;
    assign prog_in_range = {1'b0, prog_addr} < DEPTH_EXT;

    // Request acceptance: RUN only, blocked immediately by prog_en, and only
    // when the response slot is empty or draining this cycle
    always_comb begin
        fetch.req_ready = (state == RUN) && !prog_en && (!rsp_valid_q || fetch.rsp_ready);
        accept          = fetch.req_valid && fetch.req_ready;
        busy            = (state != RUN);
    end

    // Controller FSM and clear pointer; clear stops at DEPTH-1, never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state <= RUN;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (prog_en) begin
                        state <= PROG;
                    end
                end
                PROG: begin
                    if (!prog_en) begin
                        state <= RUN;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Write source mux: clear pointer writing NOP, or the programming port
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = NOP;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (state == PROG && prog_we && prog_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = prog_addr;
            mem_wdata = prog_data;
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (accept && req_in_range),
        .raddr (fetch.req_addr),
        .rdata (rd_data)
    );

    // Response valid/fault register; a held response is left untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= !req_in_range;
        end else if (fetch.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // The read register inside the array is the response data register; it is
    // only reloaded on an accepted in-range fetch, so PROG writes cannot disturb
    // it. Masking here gives NOP on reset, when idle and on faults.
    always_comb begin
        fetch.rsp_valid = rsp_valid_q;
        fetch.rsp_fault = rsp_fault_q;
        fetch.rsp_instr = (rsp_valid_q && !rsp_fault_q) ? rd_data : NOP;
    end
endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: two instances (DEPTH 16 and 12) checked
// cycle by cycle against a behavioural memory/response model.
module tb_imem_fetch;
    import imem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEP [2] = '{16, 12};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    imem_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    logic [1:0]    pe;
    logic [1:0]    pw;
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [1:0]    busy;

    imem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .fetch(if0),
        .prog_en(pe[0]), .prog_we(pw[0]), .prog_addr(pa[0]), .prog_data(pd[0]),
        .busy(busy[0])
    );

    imem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .fetch(if1),
        .prog_en(pe[1]), .prog_we(pw[1]), .prog_addr(pa[1]), .prog_data(pd[1]),
        .busy(busy[1])
    );

    // Reference model: memory image, one response slot, RUN/PROG mode
    logic [DW-1:0] mem_m [2][16];
    logic          exp_v [2];
    logic [DW-1:0] exp_i [2];
    logic          exp_f [2];
    logic          run_m [2];

    int checks = 0;
    int failures = 0;
    logic pen_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input int d, input logic rv, input logic [AW-1:0] ra, input logic rr,
                          input logic pen, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd);
        if (d == 0) begin
            if0.req_valid = rv; if0.req_addr = ra; if0.rsp_ready = rr;
        end else begin
            if1.req_valid = rv; if1.req_addr = ra; if1.rsp_ready = rr;
        end
        pe[d] = pen; pw[d] = we; pa[d] = wa; pd[d] = wd;
    endtask

    task automatic get_out(input int d, output logic rdy, output logic v, output logic f,
                           output logic bsy, output logic [DW-1:0] ins);
        if (d == 0) begin
            rdy = if0.req_ready; v = if0.rsp_valid; f = if0.rsp_fault; ins = if0.rsp_instr;
        end else begin
            rdy = if1.req_ready; v = if1.rsp_valid; f = if1.rsp_fault; ins = if1.rsp_instr;
        end
        bsy = busy[d];
    endtask

    // One clock cycle on instance d: drive, check against model, advance model
    task automatic cyc(input int d, input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic pen, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        logic rdy, v, f, bsy, exp_rdy;
        logic [DW-1:0] ins;
        set_in(d, rv, ra, rr, pen, we, wa, wd);
        #1;
        get_out(d, rdy, v, f, bsy, ins);
        exp_rdy = run_m[d] && !pen && (!exp_v[d] || rr);
        chk($sformatf("d%0d req_ready", d), 32'(rdy), 32'(exp_rdy));
        chk($sformatf("d%0d busy", d), 32'(bsy), 32'(!run_m[d]));
        chk($sformatf("d%0d rsp_valid", d), 32'(v), 32'(exp_v[d]));
        if (exp_v[d]) begin
            chk($sformatf("d%0d rsp_instr", d), 32'(ins), 32'(exp_i[d]));
            chk($sformatf("d%0d rsp_fault", d), 32'(f), 32'(exp_f[d]));
        end
        if (rv && exp_rdy) begin
            exp_v[d] = 1'b1;
            exp_f[d] = (int'(ra) >= DEP[d]);
            exp_i[d] = exp_f[d] ? '0 : mem_m[d][ra];
        end else if (rr) begin
            exp_v[d] = 1'b0;
        end
        if (!run_m[d] && we && int'(wa) < DEP[d]) mem_m[d][wa] = wd;
        run_m[d] = !pen;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        logic rdy, v, f, bsy;
        logic [DW-1:0] ins;
        for (int d = 0; d < 2; d++) begin
            get_out(d, rdy, v, f, bsy, ins);
            chk($sformatf("d%0d rst req_ready", d), 32'(rdy), 32'd0);
            chk($sformatf("d%0d rst rsp_valid", d), 32'(v), 32'd0);
            chk($sformatf("d%0d rst rsp_instr", d), 32'(ins), 32'd0);
            chk($sformatf("d%0d rst rsp_fault", d), 32'(f), 32'd0);
            chk($sformatf("d%0d rst busy", d), 32'(bsy), 32'd1);
        end
    endtask

    // Count edges after reset release until busy drops (bounded)
    task automatic wait_clear();
        int done [2];
        done[0] = -1;
        done[1] = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (done[d] < 0 && !busy[d]) done[d] = n;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d clear_cycles", d), 32'(done[d]), 32'(DEP[d]));
            for (int a = 0; a < 16; a++) mem_m[d][a] = '0;
            exp_v[d] = 1'b0;
            run_m[d] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            set_in(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
            exp_v[d] = 1'b0;
            run_m[d] = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear();

        // Every word reads back as NOP after clear
        for (int a = 0; a < 16; a++) cyc(0, 1'b1, AW'(a), 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Program three words, then fetch back-to-back
        cyc(0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd0, 16'hA016);
        cyc(0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd1, 16'h9516);
        cyc(0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd7, 16'hB000);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Held response survives a PROG write to the same address
        cyc(0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h1234);
        cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        // prog_en together with req_valid: request refused, no response
        cyc(0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        // DEPTH=12: upper addresses fault and never write
        cyc(1, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
        cyc(1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd13, 16'h5555);
        cyc(1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'd11, 16'h7777);
        cyc(1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Randomized traffic with random programming bursts, then full readback
        for (int d = 0; d < 2; d++) begin
            pen_r = 1'b0;
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 9) == 0) pen_r = !pen_r;
                cyc(d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0), pen_r, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), DW'($urandom));
            end
            cyc(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
            cyc(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
            for (int a = 0; a < 16; a++) cyc(d, 1'b1, AW'(a), 1'b1, 1'b0, 1'b0, '0, '0);
            cyc(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        end

        // Reset mid-PROG with a held response: program lost, memory cleared
        cyc(0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd2, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        reset_checks();
        set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear();
        cyc(0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, '0, '0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a clocked fetch port and a run-time programming port, sitting between the program counter and the decoder. Replaces the fixed 16x16 combinational ROM. Adds:
- configurable word width and depth;
- valid/ready fetch handshake with one-cycle read latency and output back-pressure;
- a programming mode for loading instructions after reset;
- automatic clear-to-NOP after reset;
- out-of-range fault reporting.

## Interface
Parameters:
- DATA_W, 16, instruction width in bits
- ADDR_W, 4, address width
- DEPTH, 16, number of words implemented; 1 ≤ DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when req_valid & req_ready
- req_addr  in  ADDR_W  fetch address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  DATA_W  fetched word; 0 when rsp_fault
- rsp_fault  out  1  fetch address ≥ DEPTH
- prog_en  in  1  request programming mode
- prog_we  in  1  write strobe, honoured only in PROG
- prog_addr  in  ADDR_W  write address; writes to addresses ≥ DEPTH are dropped
- prog_data  in  DATA_W  write data
- busy  out  1  high in CLEAR, or in PROG

## Operation
- FSM states: CLEAR, RUN, PROG.
- CLEAR:
  - Entered on reset.
  - clr_ptr starts at 0 and writes NOP (all zeros) to one word per cycle.
  - After the write to DEPTH-1, the FSM moves to RUN.
- RUN:
  - Fetches are served.
  - If prog_en=1, the FSM goes to PROG on the next edge.
  - prog_we is ignored.
- PROG:
  - If prog_we=1 and prog_addr<DEPTH, mem[prog_addr] <= prog_data at the edge.
  - If prog_en=0, the FSM returns to RUN on the next edge.
- req_ready = (state==RUN) & ~prog_en & (~rsp_valid | rsp_ready).
  - prog_en deasserts req_ready combinationally in the same cycle.
- Accepted request:
  - At the next edge, rsp_valid <= 1.
  - rsp_fault <= (req_addr ≥ DEPTH).
  - rsp_instr <= fault ? 0 : mem[req_addr].
- A held response (rsp_valid & ~rsp_ready) keeps rsp_instr and rsp_fault stable until accepted.
  - The response still drains while in PROG.
  - Data is not re-read.
- Back-to-back throughput: one fetch per cycle while rsp_ready=1.
- A PROG write never alters an already-registered response.

## Timing
- Reset values (asynchronous assertion):
  - req_ready=0, rsp_valid=0, rsp_instr=0, rsp_fault=0, busy=1.
  - state=CLEAR, clr_ptr=0.
- Memory contents are not reset directly. CLEAR takes exactly DEPTH cycles after rst_n deasserts; req_ready can first be 1 in cycle DEPTH.
- Reset asserted mid-CLEAR or mid-PROG: the FSM aborts immediately and restarts CLEAR from 0. A partially written program is lost.
- Fetch latency: request accepted at edge N, so rsp_valid is high after edge N and the response can be taken at edge N+1.
- Simultaneous rsp handshake and new request in one cycle: the new response replaces the old one at the same edge, with no bubble.
- prog_en rising edge while a request is presented: that request is not accepted.
- PROG write followed by a RUN fetch of the same address returns the new data. The minimum gap is one cycle for the PROG→RUN transition.
- DEPTH < 2^ADDR_W: the upper addresses always fault and never write.
- clr_ptr wraps are not permitted. The terminal count is DEPTH-1, not 2^ADDR_W-1.

## Structure
- Package imem_pkg:
  - state enum {CLEAR, RUN, PROG};
  - NOP word constant (zero);
  - opcode field width constant (4) for decoder reuse.
- Sub-module imem_array:
  - DEPTH x DATA_W storage;
  - one synchronous write port, one synchronous read port with read enable;
  - no reset on the array.
- Top level holds:
  - the FSM;
  - clr_ptr;
  - a write mux selecting CLEAR or PROG as the write source;
  - the response register and handshake logic.

## Test plan
- Reset release, DEPTH=16 → busy high for 16 cycles, then req_ready=1; fetching addr 0..15 returns 0x0000, rsp_fault=0.
- prog_en=1, then write 0xA016@0, 0x9516@1, 0xB000@7; drop prog_en; fetch 0,1,7 back-to-back → 0xA016, 0x9516, 0xB000 on consecutive cycles.
- Fetch addr 3 with rsp_ready=0 for 5 cycles while prog writes 0x1234@3 → rsp_instr holds the old value; a subsequent fetch returns 0x1234.
- DEPTH=12: fetch addr 13 → rsp_fault=1, rsp_instr=0x0000; PROG write to 13 is dropped; addr 11 behaves normally.
- rst_n pulsed low mid-PROG after writing 0xFFFF@2 → outputs return to reset values immediately; after 16 cycles of CLEAR, fetch of addr 2 returns 0x0000.
- prog_en raised in the same cycle as req_valid → req_ready=0 that cycle, and no response is generated for that request.
